fpr_mp: RTL
===========

Name: fpr_mp

Overview:
- Next-generation RV32F/RV32D floating-point register file.
- Generalised to NUM_RD read ports, NUM_WR write ports and FLEN of 32 or 64; NaN-boxes single-precision writes when FLEN=64.
- Adds a per-register pending scoreboard so decode can stall on results from long-latency FPU ops (fdiv/fsqrt) still in flight.
- Sits between decode (read ports and reservations) and the FPU/load write-back stages (write ports).

Parameters:
- NUM_FPR, 32, number of FP registers; ADDR_W = $clog2(NUM_FPR).
- FLEN, 32, register width; legal values are 32 and 64.
- NUM_RD, 3, number of read ports (rs1/rs2/rs3 for fused multiply-add).
- NUM_WR, 2, number of write ports; a higher index has higher priority.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  synchronous, active-high reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses, packed per port
- rd_data  output  NUM_RD*FLEN  read data per port
- rd_busy  output  NUM_RD  pending bit of the addressed register
- wr_en  input  NUM_WR  write strobes
- wr_addr  input  NUM_WR*ADDR_W  write addresses
- wr_data  input  NUM_WR*FLEN  write data
- wr_sp  input  NUM_WR  write is single precision (NaN-box when FLEN=64)
- rsv_en  input  1  reserve a register for an in-flight op
- rsv_addr  input  ADDR_W  register to reserve
- rsv_ack  output  1  reservation accepted
- pending  output  NUM_FPR  full scoreboard vector
- fpr  output  NUM_FPR*FLEN  all register contents (debug/CSR view)

Behaviour:
- Reset (synchronous, reset_in=1 at posedge):
  - All registers become 0 and pending becomes 0.
  - rsv_ack is 0 while reset_in=1.
  - Reset asserted mid-operation discards outstanding reservations and any same-cycle writes or reservations.
- Write:
  - On posedge with wr_en[p]=1, register wr_addr[p] is loaded with its stored value.
  - Stored value is wr_data[p], except when FLEN=64 and wr_sp[p]=1: stored = {32'hFFFF_FFFF, wr_data[p][31:0]}.
  - wr_sp is ignored when FLEN=32.
- Write collision: when several ports write the same address in one cycle, the highest-indexed port wins. Writes to different addresses all commit.
- Read:
  - Combinational; rd_data[r] = fpr[rd_addr[r]], rd_busy[r] = pending[rd_addr[r]].
  - Without bypass, a read in the cycle of a write returns the old value.
- Scoreboard, next-state per register i:
  - set when rsv_en & rsv_ack & rsv_addr==i;
  - else clear when any wr_en[p] & wr_addr[p]==i;
  - else hold.
- rsv_ack = rsv_en & ~pending[rsv_addr] & ~reset_in, combinational.
  - A reservation to an already-pending register is refused (ack=0) and changes nothing; the requester stalls.
- Reservation and write to the same register in one cycle (register not pending, so ack=1): the write updates the data and pending ends at 1, because the reservation belongs to the newer op.
- A write to a non-pending register is legal (short-latency op or load); it leaves pending at 0.
- Latency: write to read-visible is 1 cycle; reservation to rd_busy=1 is 1 cycle.
- Assertions:
  - FLEN is 32 or 64.
  - NUM_WR >= 1 and NUM_RD >= 1.
  - rsv_addr < NUM_FPR when rsv_en=1.

Optional Feature:
- Macro: FPR_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data (post NaN-boxing, highest matching write port) when its address matches an active write.
  - rd_busy[r] then reflects next-state pending, so a completing write clears busy in the same cycle unless a same-cycle reservation re-sets it.
  - Adds one combinational path from wr_data to rd_data.
- Undefined: reads and busy reflect registered state only (1-cycle write-to-read latency).

Decomposition:
- cpu_params_pkg gains:
  - NUM_FPR, FLEN (existing), FPR_ADDR_W;
  - typedefs fpr_addr_t (logic [FPR_ADDR_W-1:0]) and fpr_data_t (logic [FLEN-1:0]);
  - constant NANBOX_HI = 32'hFFFF_FFFF.
- functions_pkg gains function nanbox(data, sp), used by both the write path and the bypass path.
- One sub-module: fpr_scoreboard. It owns the pending vector, rsv_ack and the set/clear priority; its inputs are wr_en/wr_addr and rsv_en/rsv_addr.

Test Plan:
- Reset, then read all 32 registers -> rd_data=0, rd_busy=0, pending=0.
- FLEN=64: write port 0, wr_sp=1, addr 5, data 64'h0000_0000_3F80_0000; next cycle read f5 -> 64'hFFFF_FFFF_3F80_0000. With wr_sp=0 -> data stored unchanged.
- Both ports write addr 7 in one cycle, port0=32'h1111_1111 and port1=32'h2222_2222 -> f7=32'h2222_2222; a same-cycle read without bypass returns the old value.
- Reservation sequence:
  - rsv f3 -> ack=1 and next cycle rd_busy=1.
  - rsv f3 again -> ack=0, no change.
  - Write f3 -> pending[3]=0 next cycle.
  - Write f3 plus rsv f3 in the same cycle -> ack=1, pending[3] stays 1, data updated.
- Reset asserted with pending[3,9]=1 and a same-cycle write to f9 -> all pending=0, f9=0, rsv_ack=0 during reset.
- FPR_BYPASS_EN: write f12=32'hDEAD_BEEF while reading f12 with pending[12]=1 -> rd_data=DEAD_BEEF and rd_busy=0 in that cycle. Without the macro -> old data and rd_busy=1.

Source files
------------

// File: rtl/fpr_mp_pkg.sv
// Shared CPU parameters and helper functions for the FP register file.
// FPR_BYPASS_EN (optional macro) is consumed by fpr_mp, not by these packages.
package cpu_params_pkg;
    localparam int unsigned NUM_FPR    = 32;
    localparam int unsigned FLEN       = 32;
    localparam int unsigned FPR_ADDR_W = $clog2(NUM_FPR);

    typedef logic [FPR_ADDR_W-1:0] fpr_addr_t;
    typedef logic [FLEN-1:0]       fpr_data_t;

    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;
endpackage

package functions_pkg;
    import cpu_params_pkg::*;

    // Single-precision values held in a 64-bit register carry an all-ones upper half.
    function automatic logic [63:0] nanbox(input logic [63:0] data, input logic sp,
                                           input int unsigned flen);
        nanbox = data;
        if (flen == 64 && sp)
            nanbox = {NANBOX_HI, data[31:0]};
    endfunction
endpackage

// File: rtl/fpr_mp_scoreboard.sv
// Pending-result scoreboard: one bit per FP register, set by reservations and
// cleared by write-back; a same-cycle reservation wins over a clearing write.
module fpr_scoreboard #(
    parameter int unsigned NUM_FPR = cpu_params_pkg::NUM_FPR,
    parameter int unsigned NUM_WR  = 2,
    parameter int unsigned ADDR_W  = $clog2(NUM_FPR),
    parameter bit          BYPASS  = 1'b0
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ack,
    output logic [NUM_FPR-1:0]       pending,
    output logic [NUM_FPR-1:0]       busy_view
);

    logic [NUM_FPR-1:0] pend_next;

    always_comb begin
        rsv_ack = rsv_en & ~pending[rsv_addr] & ~reset_in;
    end

    always_comb begin
        pend_next = pending;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_en[p])
                pend_next[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (rsv_ack)
            pend_next[rsv_addr] = 1'b1;
        if (reset_in)
            pend_next = '0;
    end

    always_comb begin
        busy_view = BYPASS ? pend_next : pending;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            pending <= '0;
        end else begin
            pending <= pend_next;
            if (rsv_en)
                assert (32'(rsv_addr) < NUM_FPR);
        end
    end

endmodule

// File: rtl/fpr_mp.sv
// Multi-ported RV32F/D floating-point register file with pending scoreboard.
// Define FPR_BYPASS_EN to forward same-cycle write data and next-state busy to reads.
module fpr_mp
    import functions_pkg::*;
#(
    parameter int unsigned NUM_FPR = cpu_params_pkg::NUM_FPR,
    parameter int unsigned FLEN    = cpu_params_pkg::FLEN,
    parameter int unsigned NUM_RD  = 3,
    parameter int unsigned NUM_WR  = 2,
    localparam int unsigned ADDR_W = $clog2(NUM_FPR)
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*FLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*FLEN-1:0]   wr_data,
    input  logic [NUM_WR-1:0]        wr_sp,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ack,
    output logic [NUM_FPR-1:0]       pending,
    output logic [NUM_FPR*FLEN-1:0]  fpr
);

`ifdef FPR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [FLEN-1:0]    regs   [NUM_FPR];
    logic [FLEN-1:0]    wr_val [NUM_WR];
    logic [NUM_FPR-1:0] busy_view;

    fpr_scoreboard #(
        .NUM_FPR (NUM_FPR),
        .NUM_WR  (NUM_WR),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ack   (rsv_ack),
        .pending   (pending),
        .busy_view (busy_view)
    );

    // Widen to 64 bits so one nanbox helper serves both FLEN settings.
    always_comb begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            logic [63:0] raw;
            raw = '0;
            raw[FLEN-1:0] = wr_data[p*FLEN +: FLEN];
            raw = nanbox(raw, wr_sp[p], FLEN);
            wr_val[p] = raw[FLEN-1:0];
        end
    end

    // Ascending port order makes the highest-indexed colliding write land last.
    always_ff @(posedge clk_in) begin
        assert (FLEN == 32 || FLEN == 64);
        assert (NUM_WR >= 1 && NUM_RD >= 1);
        if (reset_in) begin
            for (int unsigned i = 0; i < NUM_FPR; i++)
                regs[i] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_en[p])
                    regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_val[p];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_FPR; i++)
            fpr[i*FLEN +: FLEN] = regs[i];
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            logic [ADDR_W-1:0] ra;
            ra = rd_addr[r*ADDR_W +: ADDR_W];
            rd_data[r*FLEN +: FLEN] = regs[ra];
            rd_busy[r] = busy_view[ra];
`ifdef FPR_BYPASS_EN
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (!reset_in && wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ra)
                    rd_data[r*FLEN +: FLEN] = wr_val[p];
            end
`endif
        end
    end

endmodule
